mult_share_sched: RTL
=====================

Name: mult_share_sched

Overview:
- Schedules one shared pipelined array multiplier among NREQ requesters.
- Round-robin arbitration of operand requests; operands are registered into the multiplier.
- A tag pipeline tracks each in-flight product, and returned products are queued in a result FIFO.
- A credit check guarantees every issued product has a FIFO slot. The multiplier needs no stall.

Parameters:
- WIDTH, 8, operand width; product width is 2*WIDTH.
- NREQ, 4, number of requesters (>=2).
- LAT, 2, multiplier latency in cycles: from the cycle mul_a/mul_b are presented to the cycle mul_y is valid.
- FIFO_DEPTH, 4, result FIFO entries (>=1); power of two.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  NREQ  per-requester operand valid.
- req_a  in  NREQ*WIDTH  packed operand a; requester i at [i*WIDTH +: WIDTH].
- req_b  in  NREQ*WIDTH  packed operand b, same packing.
- req_ready  out  NREQ  one-hot grant; handshake = req_valid[i] & req_ready[i].
- mul_a  out  WIDTH  registered operand a to the multiplier.
- mul_b  out  WIDTH  registered operand b to the multiplier.
- mul_y  in  2*WIDTH  multiplier product.
- rsp_valid  out  1  result available at FIFO head.
- rsp_id  out  clog2(NREQ)  requester index of the head result.
- rsp_y  out  2*WIDTH  head product.
- rsp_ready  in  1  result consumer accept.
- busy  out  1  high if any product is in flight or the FIFO is non-empty.

Behaviour:
- Reset
  - Clears the tag pipe, FIFO pointers and count, and the in-flight count.
  - Sets the RR pointer to NREQ-1, so requester 0 has highest priority first.
  - Outputs after reset: mul_a=0, mul_b=0, rsp_valid=0, busy=0, req_ready=0.
  - Reset mid-operation discards all in-flight products and queued results; mul_y is ignored until new issues return.
- Credit
  - can_issue = (inflight + fifo_count) < FIFO_DEPTH, evaluated on registered pre-cycle values.
  - A pop in the same cycle frees its credit only from the next cycle.
- Arbitration (combinational)
  - When can_issue, req_ready grants the first requester with req_valid set, searching upward from (last_grant+1) mod NREQ.
  - Otherwise req_ready=0.
  - req_ready never depends on rsp_ready in the same cycle.
- Issue cycle t
  - mul_a/mul_b load the granted operands at the end of t and are presented in t+1.
  - A tag {valid, id} enters a (1+LAT)-stage shift register.
  - last_grant and inflight are updated.
  - With no issue, mul_a/mul_b hold their values (see Optional Feature).
- Return
  - When the tag exits the shift register (cycle t+1+LAT), mul_y and the id are written to the FIFO and inflight decrements.
  - Simultaneous issue and return leave inflight unchanged.
- Response
  - FIFO is show-ahead: rsp_valid = fifo non-empty.
  - rsp_id/rsp_y are stable while rsp_valid & !rsp_ready.
  - Pop on rsp_valid & rsp_ready.
  - Push and pop in the same cycle are both allowed, including on a full FIFO, which stays full.
- Latency and throughput
  - Minimum request handshake to rsp_valid: LAT+2 cycles.
  - Sustained throughput: 1 issue per cycle when FIFO_DEPTH >= LAT+2 and rsp_ready=1.
- Ordering
  - Results leave in issue order.
  - Per-requester order is preserved.
- Pointers wrap modulo FIFO_DEPTH. Overflow is impossible by credit.

Optional Feature:
- Macro: MULT_SHARE_SCHED_ZERO_IDLE_EN.
- Defined: on cycles without an issue, mul_a/mul_b load 0. This reduces array toggle power.
- Undefined: mul_a/mul_b hold their last issued values.
- Results and handshake timing are identical either way.

Decomposition:
- Shared package mult_share_pkg:
  - IDW = clog2(NREQ) helper.
  - Tag type {valid, id}.
  - Result entry type {id, y}.
- One sub-module: mult_share_rr_arb, the round-robin arbiter (req vector, enable, last pointer -> one-hot grant plus encoded index).
- The FIFO and tag pipe stay inline.

Test Plan (defaults, LAT=2, FIFO_DEPTH=4):
- Single request: req 2 presents a=13, b=11 at cycle 0 -> req_ready[2]=1 at cycle 0; rsp_valid at cycle 4 with rsp_id=2, rsp_y=143.
- All four requesters held valid with rsp_ready=1 -> grants 0,1,2,3,0,... one per cycle; rsp_y matches each a*b in grant order; no gaps in steady state.
- Backpressure: rsp_ready=0, all valid -> exactly 4 grants, then req_ready=0. Raise rsp_ready -> 4 results drain in order and issue resumes one cycle after the first pop.
- Boundary: a=255, b=255 -> rsp_y=65025; a=0, b=200 -> rsp_y=0.
- Reset mid-stream: assert rst for 1 cycle with 2 products in flight and 1 queued -> rsp_valid=0 and busy=0 next cycle; mul_a=mul_b=0; the next grant goes to requester 0.
- Build with MULT_SHARE_SCHED_ZERO_IDLE_EN: idle cycle between issues -> mul_a=mul_b=0 in that cycle; results identical to the non-macro build.

Source files
------------

// File: rtl/mult_share_pkg.sv
// Shared types and helpers for the shared-multiplier scheduler and its arbiter.
package mult_share_pkg;

  localparam int MS_WIDTH = 8;
  localparam int MS_NREQ  = 4;

  function automatic int idw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int MS_IDW = idw(MS_NREQ);

  typedef struct packed {
    logic              vld;
    logic [MS_IDW-1:0] id;
  } tag_t;

  typedef struct packed {
    logic [MS_IDW-1:0]     id;
    logic [2*MS_WIDTH-1:0] y;
  } ent_t;

endpackage

// File: rtl/mult_share_rr_arb.sv
// Round-robin arbiter: searches upward from (i_last+1) mod NREQ and returns a
// one-hot grant plus its encoded index; no grant when i_en is low.
module mult_share_rr_arb
  import mult_share_pkg::*;
#(
  parameter int NREQ = MS_NREQ,
  parameter int IDW  = idw(NREQ)
) (
  input  logic [NREQ-1:0] i_req,
  input  logic            i_en,
  input  logic [IDW-1:0]  i_last,
  output logic [NREQ-1:0] o_gnt,
  output logic [IDW-1:0]  o_idx
);

  logic           w_found;
  logic [IDW-1:0] w_cand;

  always_comb begin
    o_gnt   = '0;
    o_idx   = '0;
    w_found = 1'b0;
    w_cand  = '0;
    for (int k = 1; k <= NREQ; k++) begin
      w_cand = IDW'((int'(i_last) + k) % NREQ);
      if (i_en && !w_found && i_req[w_cand]) begin
        o_gnt[w_cand] = 1'b1;
        o_idx         = w_cand;
        w_found       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mult_share_sched.sv
// Shares one pipelined multiplier among NREQ requesters with credit-based issue,
// a tag pipe and a show-ahead result FIFO. Option: MULT_SHARE_SCHED_ZERO_IDLE_EN.
module mult_share_sched
  import mult_share_pkg::*;
#(
  parameter int WIDTH      = MS_WIDTH,
  parameter int NREQ       = MS_NREQ,
  parameter int LAT        = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req_valid,
  input  logic [NREQ*WIDTH-1:0]   req_a,
  input  logic [NREQ*WIDTH-1:0]   req_b,
  output logic [NREQ-1:0]         req_ready,
  output logic [WIDTH-1:0]        mul_a,
  output logic [WIDTH-1:0]        mul_b,
  input  logic [2*WIDTH-1:0]      mul_y,
  output logic                    rsp_valid,
  output logic [idw(NREQ)-1:0]    rsp_id,
  output logic [2*WIDTH-1:0]      rsp_y,
  input  logic                    rsp_ready,
  output logic                    busy
);

  localparam int IDW = idw(NREQ);
  localparam int AW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW  = $clog2(FIFO_DEPTH + 1);

  // Tag and FIFO records come from the package, which is sized for this width/requester count.
  if (WIDTH != MS_WIDTH || NREQ != MS_NREQ) begin : g_cfg_err
    $error("mult_share_sched: WIDTH/NREQ must match mult_share_pkg record sizes");
  end

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  logic [IDW-1:0]   r_last;
  logic [CW-1:0]    r_inflight;
  logic [CW-1:0]    r_count;
  logic [AW-1:0]    r_wr;
  logic [AW-1:0]    r_rd;
  logic [WIDTH-1:0] r_mul_a;
  logic [WIDTH-1:0] r_mul_b;
  tag_t             r_tag_p [0:LAT];
  ent_t             r_mem   [0:FIFO_DEPTH-1];

  logic             w_can_issue;
  logic             w_issue;
  logic             w_push;
  logic             w_pop;
  logic [NREQ-1:0]  w_gnt;
  logic [IDW-1:0]   w_gnt_idx;
  logic [WIDTH-1:0] w_a;
  logic [WIDTH-1:0] w_b;

  // Every issued product already owns a FIFO slot, so the multiplier never stalls.
  assign w_can_issue = (int'(r_inflight) + int'(r_count)) < FIFO_DEPTH;

  mult_share_rr_arb #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_arb (
    .i_req  (req_valid),
    .i_en   (w_can_issue & ~rst),
    .i_last (r_last),
    .o_gnt  (w_gnt),
    .o_idx  (w_gnt_idx)
  );

  assign req_ready = w_gnt;
  assign w_issue   = |w_gnt;
  assign w_a       = req_a[int'(w_gnt_idx)*WIDTH +: WIDTH];
  assign w_b       = req_b[int'(w_gnt_idx)*WIDTH +: WIDTH];

  // Stage p0: operand registers feeding the multiplier
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mul_a <= '0;
      r_mul_b <= '0;
    end else if (w_issue) begin
      r_mul_a <= w_a;
      r_mul_b <= w_b;
    end
`ifdef MULT_SHARE_SCHED_ZERO_IDLE_EN
    else begin
      r_mul_a <= '0;
      r_mul_b <= '0;
    end
`endif
  end

  assign mul_a = r_mul_a;
  assign mul_b = r_mul_b;

  // Tag pipe: stage LAT lines up with the cycle mul_y is valid
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k <= LAT; k++) r_tag_p[k] <= '0;
    end else begin
      r_tag_p[0] <= '{vld: w_issue, id: w_gnt_idx};
      for (int k = 1; k <= LAT; k++) r_tag_p[k] <= r_tag_p[k-1];
    end
  end

  assign w_push = r_tag_p[LAT].vld;
  assign w_pop  = (r_count != '0) & rsp_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_last     <= IDW'(NREQ - 1);
      r_inflight <= '0;
    end else begin
      if (w_issue) r_last <= w_gnt_idx;
      case ({w_issue, w_push})
        2'b10:   r_inflight <= r_inflight + 1'b1;
        2'b01:   r_inflight <= r_inflight - 1'b1;
        default: r_inflight <= r_inflight;
      endcase
    end
  end

  // Result FIFO: show-ahead, push and pop may coincide even when full
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wr <= ptr_inc(r_wr);
      if (w_pop)  r_rd <= ptr_inc(r_rd);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr] <= '{id: r_tag_p[LAT].id, y: mul_y};
  end

  assign rsp_valid = (r_count != '0);
  assign rsp_id    = r_mem[r_rd].id;
  assign rsp_y     = r_mem[r_rd].y;
  assign busy      = (r_inflight != '0) | (r_count != '0);

endmodule
